// File: rtl/regfile_scoreboard.sv
// Integer register file with two async read ports, one writeback port and a per-register
// pending-write scoreboard. Define REGFILE_BYPASS_EN to forward same-cycle writeback to reads.
module regfile_scoreboard #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int PEND_WIDTH = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] rs1_addr,
  input  logic [ADDR_WIDTH-1:0] rs2_addr,
  output logic [DATA_WIDTH-1:0] rs1_value,
  output logic [DATA_WIDTH-1:0] rs2_value,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  input  logic                  issue_valid,
  input  logic [ADDR_WIDTH-1:0] issue_rd,
  output logic                  issue_ready,
  input  logic                  wb_valid,
  input  logic [ADDR_WIDTH-1:0] wb_addr,
  input  logic [DATA_WIDTH-1:0] wb_data,
  output logic                  wb_underflow,
  output logic [DATA_WIDTH-1:0] a0_value
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] A0_IDX  = ADDR_WIDTH'(10);
  localparam logic [PEND_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [PEND_WIDTH-1:0] CNT_ONE = PEND_WIDTH'(1);

  logic [DATA_WIDTH-1:0] rf  [DEPTH];
  logic [PEND_WIDTH-1:0] cnt [DEPTH];
  logic [DEPTH-1:0]      inc;
  logic [DEPTH-1:0]      dec;
  logic                  underflow_q;
  logic                  wb_uf;

  assign issue_ready = (issue_rd == '0) || (cnt[issue_rd] != CNT_MAX);

  // A same-cycle issue and writeback to one register cancel, even when its count is 0.
  always_comb begin
    inc = '0;
    dec = '0;
    for (int unsigned r = 1; r < DEPTH; r++) begin
      inc[r] = issue_valid && issue_ready && (issue_rd == ADDR_WIDTH'(r));
      dec[r] = wb_valid && (wb_addr == ADDR_WIDTH'(r)) && ((cnt[r] != '0) || inc[r]);
    end
  end

  assign wb_uf = wb_valid && (wb_addr != '0) && (cnt[wb_addr] == '0) && !inc[wb_addr];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned r = 0; r < DEPTH; r++) begin
        rf[r]  <= '0;
        cnt[r] <= '0;
      end
      underflow_q <= 1'b0;
    end else begin
      if (wb_valid && (wb_addr != '0))
        rf[wb_addr] <= wb_data;
      for (int unsigned r = 1; r < DEPTH; r++) begin
        if (inc[r] && !dec[r])
          cnt[r] <= cnt[r] + CNT_ONE;
        else if (dec[r] && !inc[r])
          cnt[r] <= cnt[r] - CNT_ONE;
      end
      if (wb_uf)
        underflow_q <= 1'b1;
    end
  end

  always_comb begin
    rs1_value = (rs1_addr == '0) ? '0 : rf[rs1_addr];
    rs2_value = (rs2_addr == '0) ? '0 : rf[rs2_addr];
    rs1_busy  = (rs1_addr != '0) && (cnt[rs1_addr] != '0);
    rs2_busy  = (rs2_addr != '0) && (cnt[rs2_addr] != '0);
`ifdef REGFILE_BYPASS_EN
    // The retiring write satisfies one reservation, so only further pending writes stall.
    if (wb_valid && (wb_addr == rs1_addr) && (rs1_addr != '0)) begin
      rs1_value = wb_data;
      rs1_busy  = cnt[rs1_addr] > CNT_ONE;
    end
    if (wb_valid && (wb_addr == rs2_addr) && (rs2_addr != '0)) begin
      rs2_value = wb_data;
      rs2_busy  = cnt[rs2_addr] > CNT_ONE;
    end
`endif
  end

  assign wb_underflow = underflow_q;
  assign a0_value     = rf[A0_IDX];
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: vector table, directed corner sequences and
// randomized traffic against an array-based reference model.
module tb_regfile_scoreboard;
  localparam int MAXP = 3;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  rs1_addr = '0, rs2_addr = '0, issue_rd = '0, wb_addr = '0;
  logic        issue_valid = 1'b0, wb_valid = 1'b0;
  logic [31:0] wb_data = '0;
  logic [31:0] rs1_value, rs2_value, a0_value;
  logic        rs1_busy, rs2_busy, issue_ready, wb_underflow;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] mrf [32];
  int          mcnt [32];
  bit          m_uf;

  regfile_scoreboard #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .PEND_WIDTH(2)) dut (
    .clock(clock), .reset(reset),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_value(rs1_value), .rs2_value(rs2_value),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .wb_underflow(wb_underflow), .a0_value(a0_value)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        iv;
    logic [4:0]  rd;
    logic        wv;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  rs1;
    logic [31:0] e_val;
    logic        e_busy;
    logic        e_ready;
    logic        e_uf;
  } vec_t;

  function automatic vec_t mk(input int iv, input int rd, input int wv, input int wa,
                              input logic [31:0] wd, input int rs1, input logic [31:0] ev,
                              input int eb, input int er, input int eu);
    vec_t v;
    v.iv = iv[0]; v.rd = 5'(rd); v.wv = wv[0]; v.wa = 5'(wa); v.wd = wd; v.rs1 = 5'(rs1);
    v.e_val = ev; v.e_busy = eb[0]; v.e_ready = er[0]; v.e_uf = eu[0];
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: issued-but-unretired write counts per register, applied once per edge.
  task automatic model_update();
    bit ready, inc, same;
    if (reset) begin
      for (int i = 0; i < 32; i++) begin mrf[i] = '0; mcnt[i] = 0; end
      m_uf = 1'b0;
      return;
    end
    ready = (issue_rd == 0) || (mcnt[issue_rd] != MAXP);
    inc   = issue_valid && ready && (issue_rd != 0);
    same  = inc && wb_valid && (wb_addr == issue_rd);
    if (wb_valid && wb_addr != 0 && mcnt[wb_addr] == 0 && !same) m_uf = 1'b1;
    if (!same) begin
      if (inc) mcnt[issue_rd] = mcnt[issue_rd] + 1;
      if (wb_valid && wb_addr != 0 && mcnt[wb_addr] != 0) mcnt[wb_addr] = mcnt[wb_addr] - 1;
    end
    if (wb_valid && wb_addr != 0) mrf[wb_addr] = wb_data;
  endtask

  task automatic tick();
    @(posedge clock);
    model_update();
    #1;
  endtask

  task automatic idle();
    issue_valid = 1'b0; wb_valid = 1'b0; issue_rd = '0; wb_addr = '0; wb_data = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  function automatic logic [31:0] exp_val(input logic [4:0] a);
    if (a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (wb_valid && wb_addr == a) return wb_data;
`endif
    return mrf[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a);
    if (a == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (wb_valid && wb_addr == a) return mcnt[a] > 1;
`endif
    return mcnt[a] != 0;
  endfunction

  task automatic check_all();
    chk("rs1_value", rs1_value, exp_val(rs1_addr));
    chk("rs2_value", rs2_value, exp_val(rs2_addr));
    chk("rs1_busy", 32'(rs1_busy), 32'(exp_busy(rs1_addr)));
    chk("rs2_busy", 32'(rs2_busy), 32'(exp_busy(rs2_addr)));
    chk("issue_ready", 32'(issue_ready), 32'((issue_rd == 0) || (mcnt[issue_rd] != MAXP)));
    chk("a0_value", a0_value, mrf[10]);
    chk("wb_underflow", 32'(wb_underflow), 32'(m_uf));
  endtask

  vec_t tbl[16];

  initial begin
    tbl[0]  = mk(1, 5, 0, 0, 0,            5, 0,            0, 1, 0);
    tbl[1]  = mk(0, 5, 0, 0, 0,            5, 0,            1, 1, 0);
    tbl[2]  = mk(0, 0, 1, 5, 32'hDEADBEEF, 0, 0,            0, 1, 0);
    tbl[3]  = mk(0, 0, 0, 0, 0,            5, 32'hDEADBEEF, 0, 1, 0);
    tbl[4]  = mk(1, 7, 0, 0, 0,            7, 0,            0, 1, 0);
    tbl[5]  = mk(1, 7, 0, 0, 0,            7, 0,            1, 1, 0);
    tbl[6]  = mk(1, 7, 0, 0, 0,            7, 0,            1, 1, 0);
    tbl[7]  = mk(1, 7, 0, 0, 0,            7, 0,            1, 0, 0);
    tbl[8]  = mk(1, 7, 1, 7, 32'h77,       5, 32'hDEADBEEF, 0, 0, 0);
    tbl[9]  = mk(1, 7, 0, 0, 0,            7, 32'h77,       1, 1, 0);
    tbl[10] = mk(0, 7, 0, 0, 0,            7, 32'h77,       1, 0, 0);
    tbl[11] = mk(1, 0, 1, 0, 32'h1234,     0, 0,            0, 1, 0);
    tbl[12] = mk(0, 0, 0, 0, 0,            0, 0,            0, 1, 0);
    tbl[13] = mk(0, 0, 1, 3, 32'hCAFE,     0, 0,            0, 1, 0);
    tbl[14] = mk(0, 0, 0, 0, 0,            3, 32'hCAFE,     0, 1, 1);
    tbl[15] = mk(1, 0, 0, 0, 0,            3, 32'hCAFE,     0, 1, 1);

    do_reset();

    for (int i = 0; i < 32; i++) begin
      rs1_addr = 5'(i);
      rs2_addr = 5'(31 - i);
      #1;
      chk("reset_rs1_value", rs1_value, 32'h0);
      chk("reset_rs2_value", rs2_value, 32'h0);
      chk("reset_rs1_busy", 32'(rs1_busy), 32'h0);
      chk("reset_rs2_busy", 32'(rs2_busy), 32'h0);
    end
    chk("reset_ready", 32'(issue_ready), 32'h1);
    chk("reset_underflow", 32'(wb_underflow), 32'h0);

    rs2_addr = '0;
    for (int i = 0; i < 16; i++) begin
      issue_valid = tbl[i].iv; issue_rd = tbl[i].rd;
      wb_valid = tbl[i].wv; wb_addr = tbl[i].wa; wb_data = tbl[i].wd;
      rs1_addr = tbl[i].rs1;
      #1;
      chk($sformatf("vec%0d_rs1_value", i), rs1_value, tbl[i].e_val);
      chk($sformatf("vec%0d_rs1_busy", i), 32'(rs1_busy), 32'(tbl[i].e_busy));
      chk($sformatf("vec%0d_issue_ready", i), 32'(issue_ready), 32'(tbl[i].e_ready));
      chk($sformatf("vec%0d_underflow", i), 32'(wb_underflow), 32'(tbl[i].e_uf));
      chk($sformatf("vec%0d_x0", i), dut.rs2_value, 32'h0);
      tick();
    end
    idle();

    // Same-cycle writeback and read of a register with one pending write.
    do_reset();
    issue_valid = 1'b1; issue_rd = 5'd9;
    tick();
    idle();
    wb_valid = 1'b1; wb_addr = 5'd9; wb_data = 32'hA5A5A5A5; rs2_addr = 5'd9;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("byp_rs2_value", rs2_value, 32'hA5A5A5A5);
    chk("byp_rs2_busy", 32'(rs2_busy), 32'h0);
`else
    chk("byp_rs2_value", rs2_value, 32'h0);
    chk("byp_rs2_busy", 32'(rs2_busy), 32'h1);
`endif
    tick();
    idle();
    #1;
    chk("post_wb_rs2_value", rs2_value, 32'hA5A5A5A5);
    chk("post_wb_rs2_busy", 32'(rs2_busy), 32'h0);
    chk("post_wb_underflow", 32'(wb_underflow), 32'h0);

    // Reset wins over a pending count and a concurrent writeback.
    issue_valid = 1'b1; issue_rd = 5'd4;
    tick();
    tick();
    rs1_addr = 5'd4;
    #1;
    chk("pre_rst_busy", 32'(rs1_busy), 32'h1);
    reset = 1'b1; wb_valid = 1'b1; wb_addr = 5'd4; wb_data = 32'h99;
    tick();
    reset = 1'b0;
    idle();
    #1;
    chk("rst_x4_value", rs1_value, 32'h0);
    chk("rst_x4_busy", 32'(rs1_busy), 32'h0);
    chk("rst_underflow", 32'(wb_underflow), 32'h0);
    wb_valid = 1'b1; wb_addr = 5'd4; wb_data = 32'h5;
    tick();
    idle();
    #1;
    chk("rst_cnt_zero_underflow", 32'(wb_underflow), 32'h1);
    chk("rst_x4_new_value", rs1_value, 32'h5);

    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      reset       = (cyc % 600 == 599);
      issue_valid = ($urandom_range(0, 9) < 6);
      issue_rd    = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'($urandom_range(0, 5));
      wb_valid    = ($urandom_range(0, 9) < 5);
      wb_addr     = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'($urandom_range(0, 5));
      if ($urandom_range(0, 15) == 0) wb_addr = 5'd10;
      wb_data     = $urandom;
      rs1_addr    = 5'($urandom_range(0, 7));
      rs2_addr    = ($urandom_range(0, 3) == 0) ? wb_addr : 5'($urandom);
      #1;
      check_all();
      tick();
    end
    reset = 1'b0;
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
